// File: rtl/seg7_scan_capture.sv
// Receive side of the 7-seg display path: samples a multiplexed segment bus and rebuilds one hex word per scan frame.
// Build option: define SEG7_CAPTURE_INVERT_EN for active-low (common-anode) seg/digit_en inputs.
module seg7_scan_capture #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4,
   parameter int FRAME_TIMEOUT = 1000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [6:0]              seg,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   output logic [NUM_DIGITS*4-1:0] value,
   output logic                    valid,
   output logic [NUM_DIGITS-1:0]   digit_err,
   output logic                    timeout
);

   localparam int DW = $clog2(STABLE_CYCLES + 1);
   localparam int TW = $clog2(FRAME_TIMEOUT + 1);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [DW-1:0] DWELL_MAX = DW'(STABLE_CYCLES);
   localparam logic [TW-1:0] TIMER_MAX = TW'(FRAME_TIMEOUT);

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      DONE
   } state_t;

   // Returns {err, nibble}; unknown patterns decode to 0 with err set.
   function automatic logic [4:0] decode_seg(input logic [6:0] s);
      logic [4:0] r;
      case (s)
         7'h3F:   r = 5'h00;
         7'h06:   r = 5'h01;
         7'h5B:   r = 5'h02;
         7'h4F:   r = 5'h03;
         7'h66:   r = 5'h04;
         7'h6D:   r = 5'h05;
         7'h7D:   r = 5'h06;
         7'h07:   r = 5'h07;
         7'h7F:   r = 5'h08;
         7'h6F:   r = 5'h09;
         7'h77:   r = 5'h0A;
         7'h7C:   r = 5'h0B;
         7'h39:   r = 5'h0C;
         7'h5E:   r = 5'h0D;
         7'h79:   r = 5'h0E;
         7'h71:   r = 5'h0F;
         default: r = 5'h10;
      endcase
      return r;
   endfunction

   logic [6:0]              seg_in;
   logic [NUM_DIGITS-1:0]   en_in;

`ifdef SEG7_CAPTURE_INVERT_EN
   assign seg_in = ~seg;
   assign en_in  = ~digit_en;
`else
   assign seg_in = seg;
   assign en_in  = digit_en;
`endif

   logic [6:0]              seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;
   logic [NUM_DIGITS-1:0]   en_s1_q, en_s1_d, en_s2_q, en_s2_d;
   logic [NUM_DIGITS+6:0]   prev_q, prev_d;
   logic [DW-1:0]           dwell_q, dwell_d;
   logic [NUM_DIGITS*4-1:0] slot_q, slot_d;
   logic [NUM_DIGITS-1:0]   slot_err_q, slot_err_d;
   logic                    capture;
   logic [IW-1:0]           cap_idx;
   logic [NUM_DIGITS-1:0]   cap_mask;
   logic [4:0]              decoded;

   state_t                  state_q;
   logic [TW-1:0]           timer_q;
   logic [NUM_DIGITS-1:0]   seen_q, seen_next;
   logic [NUM_DIGITS*4-1:0] value_q;
   logic [NUM_DIGITS-1:0]   err_q;
   logic                    valid_q, timeout_q;

   // Capture fires only on the transition into the saturated dwell count, so a long hold captures once.
   always_comb begin
      seg_s1_d   = seg_in;
      seg_s2_d   = seg_s1_q;
      en_s1_d    = en_in;
      en_s2_d    = en_s1_q;
      prev_d     = {seg_s2_q, en_s2_q};
      dwell_d    = dwell_q;
      slot_d     = slot_q;
      slot_err_d = slot_err_q;
      cap_idx    = '0;
      decoded    = decode_seg(seg_s2_q);

      if (({seg_s2_q, en_s2_q} != prev_q) || !$onehot(en_s2_q)) begin
         dwell_d = '0;
      end else if (dwell_q != DWELL_MAX) begin
         dwell_d = dwell_q + DW'(1);
      end

      capture  = (dwell_d == DWELL_MAX) && (dwell_q != DWELL_MAX);
      cap_mask = capture ? en_s2_q : '0;

      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (en_s2_q[i]) begin
            cap_idx = IW'(i);
         end
      end

      if (capture) begin
         slot_d[cap_idx*4 +: 4] = decoded[3:0];
         slot_err_d[cap_idx]    = decoded[4];
      end

      seen_next = seen_q | cap_mask;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_s1_q   <= '0;
         seg_s2_q   <= '0;
         en_s1_q    <= '0;
         en_s2_q    <= '0;
         prev_q     <= '0;
         dwell_q    <= '0;
         slot_q     <= '0;
         slot_err_q <= '0;
      end else begin
         seg_s1_q   <= seg_s1_d;
         seg_s2_q   <= seg_s2_d;
         en_s1_q    <= en_s1_d;
         en_s2_q    <= en_s2_d;
         prev_q     <= prev_d;
         dwell_q    <= dwell_d;
         slot_q     <= slot_d;
         slot_err_q <= slot_err_d;
      end
   end

   // Frame FSM; completion is tested before timer expiry so it wins a tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         seen_q    <= '0;
         value_q   <= '0;
         err_q     <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (capture) begin
                  seen_q  <= cap_mask;
                  timer_q <= '0;
                  state_q <= (cap_mask == '1) ? DONE : COLLECT;
               end
            end
            COLLECT: begin
               seen_q <= seen_next;
               if (seen_next == '1) begin
                  state_q <= DONE;
               end else if (timer_q >= TIMER_MAX - TW'(1)) begin
                  timeout_q <= 1'b1;
                  seen_q    <= '0;
                  state_q   <= IDLE;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            DONE: begin
               value_q <= slot_q;
               err_q   <= slot_err_q;
               valid_q <= 1'b1;
               seen_q  <= cap_mask;
               if (capture) begin
                  timer_q <= '0;
                  state_q <= (cap_mask == '1) ? DONE : COLLECT;
               end else begin
                  state_q <= IDLE;
               end
            end
            default: begin
               seen_q  <= '0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign value     = value_q;
   assign digit_err = err_q;
   assign valid     = valid_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture: table of full frames plus hand-written glitch, timeout and reset sequences.
// Honours SEG7_CAPTURE_INVERT_EN by driving active-low seg/digit_en.
module tb_seg7_scan_capture;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [6:0]  seg = '0;
   logic [3:0]  digit_en = '0;
   logic [15:0] value;
   logic        valid;
   logic [3:0]  digit_err;
   logic        timeout;

   int vectors     = 0;
   int miscompares = 0;
   int valid_cnt   = 0;
   int timeout_cnt = 0;

   typedef struct packed {
      logic [27:0] segs;
      logic [15:0] exp_value;
      logic [3:0]  exp_err;
   } frame_vec_t;

   frame_vec_t vec_table [5];

   seg7_scan_capture #(
      .NUM_DIGITS   (4),
      .STABLE_CYCLES(4),
      .FRAME_TIMEOUT(1000)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .seg      (seg),
      .digit_en (digit_en),
      .value    (value),
      .valid    (valid),
      .digit_err(digit_err),
      .timeout  (timeout)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) begin
         if (valid) valid_cnt++;
         if (timeout) timeout_cnt++;
      end
   end

   task automatic drive(input logic [6:0] s, input logic [3:0] en);
`ifdef SEG7_CAPTURE_INVERT_EN
      seg      = ~s;
      digit_en = ~en;
`else
      seg      = s;
      digit_en = en;
`endif
   endtask

   task automatic applyStimulus(input logic [6:0] s, input logic [3:0] en, input int cycles);
      drive(s, en);
      repeat (cycles) @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic run_frame(input string name, input logic [27:0] segs,
                            input logic [15:0] exp_value, input logic [3:0] exp_err);
      int v0, t0;
      v0 = valid_cnt;
      t0 = timeout_cnt;
      for (int d = 0; d < 4; d++) begin
         applyStimulus(segs[7*d +: 7], 4'(1 << d), 8);
      end
      applyStimulus(7'h00, 4'h0, 20);
      checkOutput({name, " value"}, value, exp_value);
      checkOutput({name, " digit_err"}, {12'h0, digit_err}, {12'h0, exp_err});
      checkOutput({name, " valid pulses"}, 16'(valid_cnt - v0), 16'd1);
      checkOutput({name, " timeout pulses"}, 16'(timeout_cnt - t0), 16'd0);
   endtask

   initial begin
      int v0, t0;
      vec_table[0] = '{segs: {7'h66, 7'h4F, 7'h5B, 7'h06}, exp_value: 16'h4321, exp_err: 4'b0000};
      vec_table[1] = '{segs: {7'h66, 7'h01, 7'h5B, 7'h06}, exp_value: 16'h4021, exp_err: 4'b0100};
      vec_table[2] = '{segs: {7'h6D, 7'h07, 7'h7D, 7'h3F}, exp_value: 16'h5760, exp_err: 4'b0000};
      vec_table[3] = '{segs: {7'h71, 7'h79, 7'h5E, 7'h39}, exp_value: 16'hFEDC, exp_err: 4'b0000};
      vec_table[4] = '{segs: {7'h7C, 7'h77, 7'h12, 7'h7F}, exp_value: 16'hBA08, exp_err: 4'b0010};

      drive(7'h00, 4'h0);
      repeat (3) @(negedge clk);
      checkOutput("reset value", value, 16'h0);
      checkOutput("reset flags", {13'h0, valid, timeout, |digit_err}, 16'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         run_frame($sformatf("vec%0d", i), vec_table[i].segs, vec_table[i].exp_value, vec_table[i].exp_err);
      end

      // Same digit re-captured with a new pattern: latest wins.
      v0 = valid_cnt;
      applyStimulus(7'h06, 4'b0001, 8);
      applyStimulus(7'h5B, 4'b0001, 8);
      applyStimulus(7'h4F, 4'b0010, 8);
      applyStimulus(7'h66, 4'b0100, 8);
      applyStimulus(7'h7D, 4'b1000, 8);
      applyStimulus(7'h00, 4'h0, 20);
      checkOutput("overwrite value", value, 16'h6432);
      checkOutput("overwrite valid pulses", 16'(valid_cnt - v0), 16'd1);

      // Digit 0 held too briefly: frame never completes and times out.
      v0 = valid_cnt;
      t0 = timeout_cnt;
      applyStimulus(7'h3F, 4'b0001, 3);
      applyStimulus(7'h00, 4'h0, 2);
      applyStimulus(7'h5B, 4'b0010, 8);
      applyStimulus(7'h4F, 4'b0100, 8);
      applyStimulus(7'h66, 4'b1000, 8);
      applyStimulus(7'h00, 4'h0, 1100);
      checkOutput("glitch timeout pulses", 16'(timeout_cnt - t0), 16'd1);
      checkOutput("glitch valid pulses", 16'(valid_cnt - v0), 16'd0);
      checkOutput("glitch value kept", value, 16'h6432);

      // Non-one-hot enables never start a frame, so no timeout can follow.
      v0 = valid_cnt;
      t0 = timeout_cnt;
      applyStimulus(7'h06, 4'b0011, 20);
      applyStimulus(7'h00, 4'h0, 1100);
      checkOutput("nonhot timeout pulses", 16'(timeout_cnt - t0), 16'd0);
      checkOutput("nonhot valid pulses", 16'(valid_cnt - v0), 16'd0);

      // Reset mid-frame discards the partial frame and clears outputs at once.
      applyStimulus(7'h7F, 4'b0001, 8);
      applyStimulus(7'h6F, 4'b0010, 8);
      rst = 1'b1;
      drive(7'h00, 4'h0);
      #1;
      checkOutput("midreset value", value, 16'h0);
      checkOutput("midreset flags", {12'h0, digit_err}, 16'h0);
      checkOutput("midreset pulses", {14'h0, valid, timeout}, 16'h0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      run_frame("post-reset", {7'h7C, 7'h77, 7'h6F, 7'h7F}, 16'hBA98, 4'b0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
